// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry
// processes WIDTH-bit operands LSB-first under a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, overflow_d;

  // Full-adder slice on the current LSBs of the operand shift registers
  logic s_bit, c_next;
  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      busy     <= busy_d;
      done     <= done_d;
      sum      <= sum_d;
      cout     <= cout_d;
      overflow <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    busy_d     = busy;
    done_d     = 1'b0;
    sum_d      = sum;
    cout_d     = cout;
    overflow_d = overflow;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction runs as a + ~b + ~cin; carry-out then means "no borrow"
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? ~cin : cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {s_bit, res_q[WIDTH-1:1]};
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // c_q is the carry into the MSB here, c_next the carry out of it
          sum_d      = {s_bit, res_q[WIDTH-1:1]};
          cout_d     = c_next;
          overflow_d = c_q ^ c_next;
          cnt_d      = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
